// File: rtl/fpu_issue_pipe.sv
// Two-stage EX/WB issue pipeline around the combinational bf16 FPU,
// with an FP-register busy scoreboard and a retired-op counter.
package ibex_pkg;
  typedef enum logic [2:0] {
    FP_ALU_ADD    = 3'd0,
    FP_ALU_SUB    = 3'd1,
    FP_ALU_MUL    = 3'd2,
    FP_ALU_MINMAX = 3'd3,
    FP_ALU_CMP    = 3'd4,
    FP_ALU_CLASS  = 3'd5,
    FP_ALU_CVT    = 3'd6,
    FP_ALU_SGNJ   = 3'd7
  } fp_alu_op_e;
endpackage

module fpu_issue_pipe
  import ibex_pkg::*;
#(
  parameter  int NUM_FP_REGS = 32,
  parameter  int CNT_W       = 16,
  localparam int RD_W        = $clog2(NUM_FP_REGS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  fp_alu_op_e             req_op_i,
  input  logic [31:0]            req_a_i,
  input  logic [15:0]            req_b_i,
  input  logic [1:0]             req_mode_i,
  input  logic [RD_W-1:0]        req_rd_i,
  input  logic                   flush_i,
  output fp_alu_op_e             fpu_op_o,
  output logic [31:0]            fpu_a_o,
  output logic [15:0]            fpu_b_o,
  output logic [1:0]             fpu_mode_o,
  input  logic [31:0]            fpu_result_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [31:0]            wb_data_o,
  output logic [RD_W-1:0]        wb_rd_o,
  output logic                   wb_is_int_o,
  output logic [NUM_FP_REGS-1:0] busy_o,
  output logic [CNT_W-1:0]       retired_cnt_o
);

  logic             ex_valid;
  fp_alu_op_e       ex_op;
  logic [31:0]      ex_a;
  logic [15:0]      ex_b;
  logic [1:0]       ex_mode;
  logic [RD_W-1:0]  ex_rd;
  logic             ex_is_int;

  logic             wb_valid;
  logic [31:0]      wb_data;
  logic [RD_W-1:0]  wb_rd;
  logic             wb_is_int;
  logic [CNT_W-1:0] cnt;

  logic ex_adv;
  logic accept;
  logic retire;
  logic req_is_int;

  // Compares, classify and fp->int converts target the integer RF
  always_comb begin
    req_is_int = 1'b0;
    unique case (req_op_i)
      FP_ALU_CMP,
      FP_ALU_CLASS: req_is_int = 1'b1;
      FP_ALU_CVT:   req_is_int = !req_mode_i[1];
      default:      req_is_int = 1'b0;
    endcase
  end

  assign ex_adv      = ex_valid && (!wb_valid || wb_ready_i);
  assign req_ready_o = !flush_i && (!ex_valid || ex_adv);
  assign accept      = req_valid_i && req_ready_o;
  assign retire      = wb_valid && wb_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid  <= 1'b0;
      ex_op     <= fp_alu_op_e'(3'd0);
      ex_a      <= '0;
      ex_b      <= '0;
      ex_mode   <= '0;
      ex_rd     <= '0;
      ex_is_int <= 1'b0;
    end else if (flush_i) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid  <= 1'b1;
      ex_op     <= req_op_i;
      ex_a      <= req_a_i;
      ex_b      <= req_b_i;
      ex_mode   <= req_mode_i;
      ex_rd     <= req_rd_i;
      ex_is_int <= req_is_int;
    end else if (ex_adv) begin
      ex_valid <= 1'b0;
    end
  end

  // An advancing EX op commits to WB even in a flush cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_rd     <= '0;
      wb_is_int <= 1'b0;
    end else if (ex_adv) begin
      wb_valid  <= 1'b1;
      wb_data   <= fpu_result_i;
      wb_rd     <= ex_rd;
      wb_is_int <= ex_is_int;
    end else if (retire) begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (retire) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int r = 0; r < NUM_FP_REGS; r++) begin
      busy_o[r] = (ex_valid && !ex_is_int && ex_rd == RD_W'(r)) ||
                  (wb_valid && !wb_is_int && wb_rd == RD_W'(r));
    end
  end

  assign fpu_op_o      = ex_op;
  assign fpu_a_o       = ex_a;
  assign fpu_b_o       = ex_b;
  assign fpu_mode_o    = ex_mode;
  assign wb_valid_o    = wb_valid;
  assign wb_data_o     = wb_data;
  assign wb_rd_o       = wb_rd;
  assign wb_is_int_o   = wb_is_int;
  assign retired_cnt_o = cnt;

endmodule
